collision_scanner: RTL and testbench

COLLISION_SCANNER -- requirements
Module: collision_scanner

---
 rtl/hero_pkg.sv | 15 +
 rtl/priority_enc.sv | 25 ++
 rtl/collision_scanner.sv | 112 +++++++++++
 tb/tb_collision_scanner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hero_pkg.sv
// Shared definitions for the hero wall-collision logic: scanner FSM encoding
// and default object counts, also used by the collision mux.
package hero_pkg;

    localparam int unsigned NUM_OBJ_DEF = 12;
    localparam int unsigned ACT_W_DEF   = 16;
    localparam int unsigned IDX_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/priority_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit
// of i_vec and whether any bit is set. Purely combinational.
module priority_enc
    import hero_pkg::*;
#(
    parameter int unsigned N = NUM_OBJ_DEF
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_valid_c
);

    // Walk from the top down so the lowest set bit is the last to win.
    always_comb begin
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx_c   = IDX_W'(i);
                o_valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/collision_scanner.sv
// Sequentially polls NUM_OBJ wall objects through a one-hot select and
// collects the returned collision flags into a registered hit map.
module collision_scanner
    import hero_pkg::*;
#(
    parameter int unsigned NUM_OBJ = NUM_OBJ_DEF,
    parameter int unsigned ACT_W   = ACT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               coll,
    output logic [ACT_W-1:0]   active,
    output logic               busy,
    output logic               done,
    output logic [NUM_OBJ-1:0] hit_map,
    output logic               any_hit,
    output logic [IDX_W-1:0]   first_hit
);

    scan_state_e        r_state;
    scan_state_e        w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [NUM_OBJ-1:0] r_work;
    logic [NUM_OBJ-1:0] w_work_nxt;
    logic [ACT_W-1:0]   w_active;
    logic               w_hit_load;
    logic [IDX_W-1:0]   w_pe_idx;
    logic               w_pe_valid;

    logic [NUM_OBJ-1:0] r_hit_map;
    logic               r_any_hit;
    logic [IDX_W-1:0]   r_first_hit;
    logic               r_busy;
    logic               r_done;

    // Next-state, counter and working-register update; active decodes from r_idx.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_work_nxt  = r_work;
        w_active    = '0;
        w_hit_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SCAN;
                    w_idx_nxt   = '0;
                    w_work_nxt  = '0;
                end
            end
            ST_SCAN: begin
                w_active   = ACT_W'(1) << r_idx;
                w_work_nxt = r_work | (NUM_OBJ'(coll) << r_idx);
                if (r_idx == IDX_W'(NUM_OBJ - 1)) begin
                    w_state_nxt = ST_DONE;
                    w_hit_load  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Encoder sees the final working map, including the last object's flag.
    priority_enc #(
        .N (NUM_OBJ)
    ) u_priority_enc (
        .i_vec     (w_work_nxt),
        .o_idx_c   (w_pe_idx),
        .o_valid_c (w_pe_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_work      <= '0;
            r_hit_map   <= '0;
            r_any_hit   <= 1'b0;
            r_first_hit <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_work  <= w_work_nxt;
            r_busy  <= (w_state_nxt == ST_SCAN);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_hit_load) begin
                r_hit_map   <= w_work_nxt;
                r_any_hit   <= w_pe_valid;
                r_first_hit <= w_pe_idx;
            end
        end
    end

    assign active    = w_active;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hit_map   = r_hit_map;
    assign any_hit   = r_any_hit;
    assign first_hit = r_first_hit;

endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboard bench for collision_scanner: expected scan results are queued at
// start and compared when done pulses; a behavioural mux answers active.
module tb_collision_scanner;

    localparam int unsigned NOBJ = 12;
    localparam int unsigned AW   = 16;

    typedef struct packed {
        logic [NOBJ-1:0] hit;
        logic            any;
        logic [3:0]      first;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            coll;
    logic [AW-1:0]   active;
    logic            busy;
    logic            done;
    logic [NOBJ-1:0] hit_map;
    logic            any_hit;
    logic [3:0]      first_hit;

    logic [NOBJ-1:0] mask;
    logic [NOBJ-1:0] hold_hit;
    exp_t            sb_q[$];
    exp_t            mon_e;
    int              n_checks;
    int              n_fail;
    int              n_done;

    collision_scanner #(
        .NUM_OBJ (NOBJ),
        .ACT_W   (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .coll      (coll),
        .active    (active),
        .busy      (busy),
        .done      (done),
        .hit_map   (hit_map),
        .any_hit   (any_hit),
        .first_hit (first_hit)
    );

    // Collision mux model: reports 1 when the selected object is in mask.
    assign coll = |(active[NOBJ-1:0] & mask);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [NOBJ-1:0] m);
        exp_t e;
        e.hit   = m;
        e.any   = |m;
        e.first = 4'd0;
        for (int i = int'(NOBJ) - 1; i >= 0; i--) begin
            if (m[i]) e.first = 4'(i);
        end
        return e;
    endfunction

    // Per-cycle select checker and scoreboard consumer.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("act_onehot0", 32'($onehot0(active)), 32'd1);
            if (!busy) chk("act_zero_idle", 32'(active), 32'd0);
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_hit_map", 32'(hit_map), 32'(mon_e.hit));
                    chk("sb_any_hit", 32'(any_hit), 32'(mon_e.any));
                    chk("sb_first_hit", 32'(first_hit), 32'(mon_e.first));
                    hold_hit = mon_e.hit;
                    n_done++;
                end
            end
        end
    end

    // One full scan from IDLE; called and returns at a negedge in IDLE.
    task automatic run_scan(input logic [NOBJ-1:0] m);
        mask = m;
        sb_q.push_back(model(m));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < int'(NOBJ); k++) begin
            chk("walk_active", 32'(active), 32'(16'd1 << k));
            chk("walk_busy", 32'(busy), 32'd1);
            chk("walk_hit_hold", 32'(hit_map), 32'(hold_hit));
            @(negedge clk);
        end
        chk("latency_done", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_active", 32'(active), 32'd0);
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_done   = 0;
        hold_hit = '0;
        mask     = '0;
        start    = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hit_map", 32'(hit_map), 32'd0);
        chk("rst_any_hit", 32'(any_hit), 32'd0);
        chk("rst_first_hit", 32'(first_hit), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(12'h000);
        run_scan(12'h208);

        // Abort at SCAN cycle 5: outputs clear immediately, no done.
        mask  = 12'h208;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_pre_active", 32'(active), 32'h0010);
        chk("abort_pre_hit", 32'(hit_map), 32'h208);
        rst_n = 1'b0;
        #1;
        chk("abort_active", 32'(active), 32'd0);
        chk("abort_hit_map", 32'(hit_map), 32'd0);
        chk("abort_any_hit", 32'(any_hit), 32'd0);
        chk("abort_first_hit", 32'(first_hit), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        hold_hit = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_idle", 32'(busy), 32'd0);
        end

        run_scan(12'h208);
        run_scan(12'hFFF);
        run_scan(12'h000);

        // start held high: scans every 14 cycles, DONE at offset 12.
        mask = 12'h010;
        repeat (3) sb_q.push_back(model(12'h010));
        start = 1'b1;
        for (int i = 1; i <= 42; i++) begin
            @(negedge clk);
            chk("b2b_done", 32'(done), 32'(((i - 1) % 14) == 12));
            chk("b2b_busy", 32'(busy), 32'(((i - 1) % 14) < 12));
            if (i == 41) start = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            chk("b2b_stopped", 32'(busy), 32'd0);
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("done_count", 32'(n_done), 32'd8);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
